tqvp_reg_arbiter: RTL
=====================

Name: tqvp_reg_arbiter

Overview:
Shares the single peripheral register port (address / data_in / data_write / data_out) between NUM_REQ independent requesters, e.g. the SPI register bridge and an on-chip init sequencer that preloads waveform tables. Each access is a req/gnt/ack handshake. A round-robin policy picks the winner, and the arbiter sequences a one-cycle bus write or a registered bus read. It sits between the requesters and the peripheral under test in the harness top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 4, peripheral register address width
DATA_W, 8, peripheral register data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ena  in  1  1 = new grants allowed; 0 = finish in-flight access only
req  in  NUM_REQ  per-requester access request
we  in  NUM_REQ  per-requester write(1)/read(0)
addr  in  NUM_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  per-requester write data, packed
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
ack  out  NUM_REQ  one-hot, 1-cycle pulse: access complete
rdata  out  DATA_W  read result, valid while the matching ack is high
address  out  ADDR_W  to peripheral
data_in  out  DATA_W  to peripheral (write data)
data_write  out  1  to peripheral, 1-cycle write strobe
data_out  in  DATA_W  from peripheral, combinational from address
busy  out  1  high in BUS_WR/BUS_RD

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt, ack, data_write, busy = 0; address, data_in, rdata = 0; rr pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, BUS_WR, BUS_RD. All outputs are registered.
- IDLE: if ena && |req, select the first asserted req scanning from pointer+1 mod NUM_REQ. In the same edge: latch we/addr/wdata of the winner, pulse gnt[win], set pointer=win, go to BUS_WR if we[win], else BUS_RD. If nothing is requested, stay in IDLE.
- BUS_WR (1 cycle): address=latched addr, data_in=latched wdata, data_write=1. Next edge: data_write=0, ack[win]=1, go to IDLE.
- BUS_RD (1 cycle): address=latched addr, data_write=0. Next edge: rdata<=data_out, ack[win]=1, go to IDLE.
- Latency: req sampled at edge 0 gives gnt in cycle 1, the bus op in cycle 2 and ack in cycle 3. IDLE may grant again while ack is high, so back-to-back throughput is one access per 2 cycles.
- Requester rules: hold req/we/addr/wdata stable until gnt is seen. Drop req in the gnt cycle or keep it high for the next access; a held req is re-arbitrated fairly. Changing fields before gnt has undefined effect on that requester only.
- Outside BUS_WR, address and data_in hold their last value and data_write=0. There are never two writes per grant.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- ena low: no new gnt. An in-flight access completes and acks normally.
- rdata holds its value until the next read completes; it is not updated by writes.
- A requester index with no req is never granted. gnt and ack are always one-hot or zero.
- Reset mid-access: the access is abandoned with no ack. If rst asserts during BUS_WR, data_write drops immediately (async).

Decomposition:
- Shared package tqvp_pkg: state encoding (IDLE=0, BUS_WR=1, BUS_RD=2), ADDR_W/DATA_W defaults.
- One sub-module: tqvp_rr_pick (combinational round-robin selector: req vector + pointer -> one-hot winner + index). The FSM stays in tqvp_reg_arbiter.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x3, wdata0=0xA5 -> gnt[0] in cycle 1; address=0x3, data_in=0xA5, data_write=1 for exactly cycle 2; ack[0] in cycle 3.
- Single read: peripheral model returns 0x5C at addr 0x7; req1 read addr 0x7 -> ack[1] with rdata=0x5C; data_write stays 0 throughout.
- Contention: req0 and req1 held continuously, alternating writes -> grant order 0,1,0,1 after reset; gnt every 2 cycles; no requester waits more than 1 grant.
- ena gating: ena=0 with req0=1 for 10 cycles -> no gnt. Raise ena -> gnt[0] next cycle. Drop ena during BUS_WR -> ack still issued.
- Reset mid-access: assert rst during BUS_WR -> data_write=0 immediately, no ack. After release, first grant goes to requester 0.
- Pointer wrap (NUM_REQ=3): only req2 then req0 asserted -> grants 2 then 0, with pointer wrapping correctly.

Source files
------------

// File: rtl/tqvp_reg_arbiter_pkg.sv
// Shared types for the peripheral register-port arbiter: FSM encoding and bus width defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tqvp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS_WR = 2'd1,
    BUS_RD = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tqvp_reg_arbiter_rr_pick.sv
// Round-robin selector: first asserted req scanning upward from ptr+1, wrapping mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is consumed.
// Ports: req (request vector), ptr (last winner) -> win_oh (one-hot), win_idx, win_vld.
module tqvp_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_vld
);

  always_comb begin
    int cand;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = 0;
    // k runs to NUM_REQ so the last winner itself is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!win_vld && req[PTR_W'(cand)]) begin
        win_vld              = 1'b1;
        win_idx              = PTR_W'(cand);
        win_oh[PTR_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Shares one peripheral register port between NUM_REQ requesters via req/gnt/ack, round-robin.
// Latency: req sampled at edge 0 -> gnt cycle 1, bus op cycle 2, ack (and rdata) cycle 3.
// Backpressure: requesters hold req until gnt; ena=0 blocks new grants but lets in-flight finish.
// Ports: clk/rst; ena; req/we/addr/wdata (packed per requester); gnt/ack/rdata back to
//        requesters; address/data_in/data_write/data_out to the peripheral; busy.
module tqvp_reg_arbiter
  import tqvp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         data_in,
  output logic                      data_write,
  input  logic [DATA_W-1:0]         data_out,
  output logic                      busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    cur_idx;
  logic                cur_we;
  logic                pend;       // bus op issued last cycle, ack due at this IDLE edge
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win_idx;
  logic                win_vld;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  tqvp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign win_we    = we[win_idx];
  assign win_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];

  // The bus cycle is driven from the BUS_* state's edge, so the FSM is already back in IDLE
  // while the strobe is on the bus; that IDLE edge both acks the old access and may grant
  // the next one, giving one access per two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= PTR_W'(NUM_REQ-1);
      cur_idx    <= '0;
      cur_we     <= 1'b0;
      pend       <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      address    <= '0;
      data_in    <= '0;
      data_write <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gnt        <= '0;
      ack        <= '0;
      data_write <= 1'b0;
      busy       <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            ack  <= NUM_REQ'(1) << cur_idx;
            pend <= 1'b0;
            if (!cur_we) rdata <= data_out;
          end
          if (ena && win_vld) begin
            gnt       <= win_oh;
            ptr       <= win_idx;
            cur_idx   <= win_idx;
            cur_we    <= win_we;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            busy      <= 1'b1;
            state     <= win_we ? BUS_WR : BUS_RD;
          end
        end
        BUS_WR: begin
          address    <= lat_addr;
          data_in    <= lat_wdata;
          data_write <= 1'b1;
          pend       <= 1'b1;
          state      <= IDLE;
        end
        BUS_RD: begin
          address <= lat_addr;
          pend    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
